// File: rtl/sa_load_controller.sv
// Load/compute sequencer for the systolic array: streams ROWS rows into the register file,
// flushes, runs a fixed compute window, then pulses done_o. Optional abort_i via SA_LOAD_CTRL_ABORT_EN.
module sa_load_controller #(
  parameter int DATA_W         = 16,
  parameter int LANES          = 16,
  parameter int ROWS           = 8,
  parameter int IDX_W          = 3,
  parameter int FLUSH_CYCLES   = 2,
  parameter int COMPUTE_CYCLES = 30
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
`ifdef SA_LOAD_CTRL_ABORT_EN
  input  logic                    abort_i,
`endif
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [LANES*DATA_W-1:0] s_data_i,
  output logic                    sa_en_o,
  output logic                    sa_rf_en_o,
  output logic                    sa_write_o,
  output logic [IDX_W-1:0]        sa_idx_o,
  output logic [LANES*DATA_W-1:0] sa_din_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] FLUSH   = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] DONE_ST = 3'd4;

  localparam int CNT_MAX = (FLUSH_CYCLES > COMPUTE_CYCLES) ? FLUSH_CYCLES : COMPUTE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W:0]   ROW_LAST     = (IDX_W+1)'(ROWS - 1);
  localparam logic [IDX_W:0]   ROW_ONE      = (IDX_W+1)'(1);
  localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [2:0]              state_q, state_d;
  logic [IDX_W:0]          row_q, row_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic                    rf_en_q, rf_en_d;
  logic                    write_q, write_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LANES*DATA_W-1:0] din_q, din_d;
  logic                    done_q, done_d;
  logic                    abort;

`ifdef SA_LOAD_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rf_en_d = rf_en_q;
    write_d = write_q;
    idx_d   = idx_q;
    din_d   = din_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        en_d    = 1'b0;
        rf_en_d = 1'b0;
        write_d = 1'b0;
        if (start_i) begin
          state_d = LOAD;
          en_d    = 1'b1;
          rf_en_d = 1'b1;
          write_d = 1'b1;
          row_d   = '0;
        end
      end
      LOAD: begin
        // Abort takes priority over a coincident beat so the register file row is not touched.
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid_i) begin
          din_d = s_data_i;
          idx_d = row_q[IDX_W-1:0];
          row_d = row_q + ROW_ONE;
          if (row_q == ROW_LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end
        end
      end
      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          write_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      COMPUTE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == COMPUTE_LAST) begin
          state_d = DONE_ST;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE_ST: begin
        state_d = IDLE;
        en_d    = 1'b0;
        rf_en_d = 1'b0;
        write_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        rf_en_d = 1'b0;
        write_d = 1'b0;
      end
    endcase
    if (abort && (state_q == LOAD || state_q == FLUSH || state_q == COMPUTE)) begin
      en_d    = 1'b0;
      rf_en_d = 1'b0;
      write_d = 1'b0;
      row_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rf_en_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rf_en_q <= rf_en_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  assign s_ready_o  = (state_q == LOAD);
  assign busy_o     = (state_q != IDLE);
  assign sa_en_o    = en_q;
  assign sa_rf_en_o = rf_en_q;
  assign sa_write_o = write_q;
  assign sa_idx_o   = idx_q;
  assign sa_din_o   = din_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sa_load_controller.sv
// Directed bench for sa_load_controller at default parameters; expectations are hand-derived edge numbers.
module tb_sa_load_controller;
  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int ROWS   = 8;
  localparam int IDX_W  = 3;
  localparam int FC     = 2;
  localparam int CC     = 30;
  localparam int W      = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     s_data = '0;
  logic             sa_en, sa_rf_en, sa_write, busy, done;
  logic [IDX_W-1:0] sa_idx;
  logic [W-1:0]     sa_din;
`ifdef SA_LOAD_CTRL_ABORT_EN
  logic             abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_load_controller #(
    .DATA_W(DATA_W), .LANES(LANES), .ROWS(ROWS), .IDX_W(IDX_W),
    .FLUSH_CYCLES(FC), .COMPUTE_CYCLES(CC)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
`ifdef SA_LOAD_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .s_data_i(s_data),
    .sa_en_o(sa_en),
    .sa_rf_en_o(sa_rf_en),
    .sa_write_o(sa_write),
    .sa_idx_o(sa_idx),
    .sa_din_o(sa_din),
    .busy_o(busy),
    .done_o(done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input int v);
    logic [DATA_W-1:0] lane;
    lane = DATA_W'(v);
    return {LANES{lane}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, W'(sa_en), W'(0));
    check({tag, "_rf_en"}, W'(sa_rf_en), W'(0));
    check({tag, "_write"}, W'(sa_write), W'(0));
    check({tag, "_idx"}, W'(sa_idx), W'(0));
    check({tag, "_din"}, sa_din, W'(0));
    check({tag, "_ready"}, W'(s_ready), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
  endtask

  // One job; row r carries value r+1 on every lane. Edge 0 is the START-sampling edge.
  task automatic run_job(input string name, input int stall_start, input int stall_len,
                         input int valid_cycles, input bit hold_start, input int exp_done_edge);
    int taken, last, fin;
    bit valid, beat;
    start = 1'b1;
    s_valid = 1'b0;
    tick();
    if (!hold_start) start = 1'b0;
    check("start_busy", W'(busy), W'(1));
    check("start_write", W'(sa_write), W'(1));
    taken = 0;
    last = 0;
    fin = 0;
    for (int e = 1; e <= 200 && fin == 0; e++) begin
      valid = (e <= valid_cycles) && !(e >= stall_start && e < stall_start + stall_len);
      s_valid = valid;
      s_data = rep(taken + 1);
      check("ready", W'(s_ready), W'(taken < ROWS));
      beat = valid && (taken < ROWS);
      tick();
      if (beat) begin
        taken++;
        if (taken == ROWS) last = e;
      end
      if (taken > 0) begin
        check("idx", W'(sa_idx), W'(taken - 1));
        check("din", sa_din, rep(taken));
      end
      check("write", W'(sa_write), W'((last == 0) || (e < last + FC)));
      check("en", W'(sa_en), W'((last == 0) || (e <= last + FC + CC)));
      check("busy", W'(busy), W'((last == 0) || (e <= last + FC + CC)));
      check("done", W'(done), W'((last != 0) && (e == last + FC + CC)));
      if (last != 0 && e == last + FC + CC + 1) fin = 1;
    end
    check("job_finished", W'(fin), W'(1));
    check("beats", W'(taken), W'(ROWS));
    check("done_edge", W'(last + FC + CC), W'(exp_done_edge));
    s_valid = 1'b0;
    $display("job %s: %0d beats, done after edge %0d", name, taken, last + FC + CC);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    #10 rst_n = 1'b1;

    run_job("nostall", 1000, 0, ROWS, 1'b0, 40);
    run_job("stall", 5, 3, 1000, 1'b0, 43);
    run_job("valid12", 1000, 0, 12, 1'b0, 40);
    run_job("hold_start", 1000, 0, 1000, 1'b1, 40);
    run_job("after_hold", 1000, 0, 1000, 1'b0, 40);

    // Async reset in the middle of COMPUTE.
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      s_data = rep(i + 1);
      tick();
    end
    s_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_write", W'(sa_write), W'(0));
    check("pre_rst_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    #2 rst_n = 1'b1;
    $display("reset applied mid-compute");
    run_job("post_reset", 1000, 0, 1000, 1'b0, 40);

`ifdef SA_LOAD_CTRL_ABORT_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = rep(i + 1);
      tick();
    end
    s_data = rep(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    check("abort_idx", W'(sa_idx), W'(4));
    check("abort_din", sa_din, rep(5));
    check("abort_en", W'(sa_en), W'(0));
    check("abort_write", W'(sa_write), W'(0));
    check("abort_ready", W'(s_ready), W'(0));
    check("abort_busy", W'(busy), W'(0));
    for (int i = 0; i < 45; i++) begin
      tick();
      check("abort_no_done", W'(done), W'(0));
    end
    $display("abort at row 5 beat");
    run_job("post_abort", 1000, 0, 1000, 1'b0, 40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
